// File: rtl/cpu_rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_rf_pkg (package)
//  Purpose  : Shared register-file definitions for the CPU datapath:
//             default width and depth, data/select typedefs, and the range
//             check used by the write-back and read logic.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_rf_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_SEL_W    = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_SEL_W-1:0]  sel_t;

  // True when a select addresses an implemented register. NUM_REGS need not
  // be a power of two, so the top select codes may be unused.
  function automatic logic reg_in_range(input int unsigned sel,
                                        input int unsigned num_regs);
    return (sel < num_regs);
  endfunction

endpackage : cpu_rf_pkg
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : rf_read_port
//  Purpose  : One combinational register-file read port. Selects a register
//             and its busy bit, forces 0 for out-of-range selects and for a
//             hard-wired zero register, and optionally bypasses the
//             write-back value in the same cycle.
//  Config   : RD_WB_REGFILE_BYPASS_EN - enable same-cycle write-back bypass.
//  Ports    : rs_sel      in   read select
//             regs_flat   in   stored registers, reg i at [i*DATA_W +: DATA_W]
//             busy_vec    in   stored scoreboard
//             wb_valid/wb_sel/wb_data, iss_valid/iss_sel  in  bypass inputs
//             rd_data     out  read data
//             rd_busy     out  read register has an outstanding write
//  Revision : 1.0  initial release
// ============================================================================
module rf_read_port
  import cpu_rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SEL_W    = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0
) (
  input  logic [SEL_W-1:0]           rs_sel,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic [NUM_REGS-1:0]        busy_vec,
  input  logic                       wb_valid,
  input  logic [SEL_W-1:0]           wb_sel,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       iss_valid,
  input  logic [SEL_W-1:0]           iss_sel,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_busy
);

  logic              w_sel_ok;
  logic [DATA_W-1:0] w_data;
  logic              w_busy;

  // A select is readable when it hits an implemented register that is not
  // the hard-wired zero register.
  assign w_sel_ok = reg_in_range(int'(rs_sel), NUM_REGS) &&
                    !((ZERO_REG != 0) && (rs_sel == '0));

  always_comb begin
    w_data = '0;
    w_busy = 1'b0;
    // Explicit compare loop avoids ever indexing past the array for
    // unimplemented select codes.
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(rs_sel) == i) begin
        w_data = regs_flat[i*DATA_W +: DATA_W];
        w_busy = busy_vec[i];
      end
    end
    if (!w_sel_ok) begin
      w_data = '0;
      w_busy = 1'b0;
    end
`ifdef RD_WB_REGFILE_BYPASS_EN
    // The write-back lands this edge, so the value is already final; the
    // register stays busy only if a new issue targets it in the same cycle.
    if (w_sel_ok && wb_valid && (wb_sel == rs_sel)) begin
      w_data = wb_data;
      w_busy = iss_valid && (iss_sel == rs_sel);
    end
`endif
  end

`ifndef RD_WB_REGFILE_BYPASS_EN
  // Bypass inputs are not consumed in the registered-read build.
  logic w_unused_bypass;
  assign w_unused_bypass = ^{wb_valid, wb_sel, wb_data, iss_valid, iss_sel};
`endif

  assign rd_data = w_data;
  assign rd_busy = w_busy;

endmodule : rf_read_port
`default_nettype wire

// File: rtl/rd_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : rd_wb_regfile
//  Purpose  : Clocked register array with one write-back port, two read
//             ports and a per-register busy scoreboard. Issue marks a
//             destination busy; write-back stores data and clears busy
//             (a same-cycle issue to the same register wins).
//  Config   : RD_WB_REGFILE_BYPASS_EN - same-cycle write-back to read bypass.
//  Ports    : clk, rst (sync, active high)
//             wb_valid/wb_sel/wb_data    write-back request
//             iss_valid/iss_sel          mark destination busy
//             rs1_sel -> rs1_data/rs1_busy, rs2_sel -> rs2_data/rs2_busy
//             busy_vec                   scoreboard, bit i = reg i busy
//             regs_flat                  all registers, reg i at [i*DATA_W +: DATA_W]
//  Revision : 1.0  initial release
// ============================================================================
module rd_wb_regfile
  import cpu_rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SEL_W    = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  input  logic [SEL_W-1:0]           wb_sel,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       iss_valid,
  input  logic [SEL_W-1:0]           iss_sel,
  input  logic [SEL_W-1:0]           rs1_sel,
  output logic [DATA_W-1:0]          rs1_data,
  output logic                       rs1_busy,
  input  logic [SEL_W-1:0]           rs2_sel,
  output logic [DATA_W-1:0]          rs2_data,
  output logic                       rs2_busy,
  output logic [NUM_REGS-1:0]        busy_vec,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_wr_en;
  logic [NUM_REGS-1:0] w_iss_en;

  // One-hot enables; out-of-range selects match no index and are dropped.
  always_comb begin
    w_wr_en  = '0;
    w_iss_en = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!((ZERO_REG != 0) && (i == 0))) begin
        w_wr_en[i]  = wb_valid  && (int'(wb_sel)  == i);
        w_iss_en[i] = iss_valid && (int'(iss_sel) == i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_en[i]) begin
          r_regs[i] <= wb_data;
        end
        // A new issue outranks the write-back that retires the old one.
        if (w_iss_en[i]) begin
          r_busy[i] <= 1'b1;
        end else if (w_wr_en[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    assign regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
  end

  assign busy_vec = r_busy;

  rf_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W),
    .ZERO_REG (ZERO_REG)
  ) u_rd1 (
    .rs_sel    (rs1_sel),
    .regs_flat (regs_flat),
    .busy_vec  (r_busy),
    .wb_valid  (wb_valid),
    .wb_sel    (wb_sel),
    .wb_data   (wb_data),
    .iss_valid (iss_valid),
    .iss_sel   (iss_sel),
    .rd_data   (rs1_data),
    .rd_busy   (rs1_busy)
  );

  rf_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W),
    .ZERO_REG (ZERO_REG)
  ) u_rd2 (
    .rs_sel    (rs2_sel),
    .regs_flat (regs_flat),
    .busy_vec  (r_busy),
    .wb_valid  (wb_valid),
    .wb_sel    (wb_sel),
    .wb_data   (wb_data),
    .iss_valid (iss_valid),
    .iss_sel   (iss_sel),
    .rd_data   (rs2_data),
    .rd_busy   (rs2_busy)
  );

endmodule : rd_wb_regfile
`default_nettype wire

// File: tb/tb_rd_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rd_wb_regfile
//  Purpose  : Self-checking bench for rd_wb_regfile. Three instances share
//             one stimulus: default (16 regs), ZERO_REG=1, and NUM_REGS=12.
//  Config   : RD_WB_REGFILE_BYPASS_EN - selects bypass expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rd_wb_regfile;
  import cpu_rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_sel = '0;
  logic [15:0] wb_data = '0;
  logic        iss_valid = 1'b0;
  logic [3:0]  iss_sel = '0;
  logic [3:0]  rs1_sel = '0;
  logic [3:0]  rs2_sel = '0;

  logic [15:0]  d_rs1_data, d_rs2_data, z_rs1_data, z_rs2_data, n_rs1_data, n_rs2_data;
  logic         d_rs1_busy, d_rs2_busy, z_rs1_busy, z_rs2_busy, n_rs1_busy, n_rs2_busy;
  logic [15:0]  d_busy_vec, z_busy_vec;
  logic [11:0]  n_busy_vec;
  logic [255:0] d_regs_flat, z_regs_flat;
  logic [191:0] n_regs_flat;

  always #5 clk = ~clk;

  rd_wb_regfile #(.DATA_W(16), .NUM_REGS(16), .ZERO_REG(0)) u_d (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_sel(iss_sel),
    .rs1_sel(rs1_sel), .rs1_data(d_rs1_data), .rs1_busy(d_rs1_busy),
    .rs2_sel(rs2_sel), .rs2_data(d_rs2_data), .rs2_busy(d_rs2_busy),
    .busy_vec(d_busy_vec), .regs_flat(d_regs_flat));

  rd_wb_regfile #(.DATA_W(16), .NUM_REGS(16), .ZERO_REG(1)) u_z (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_sel(iss_sel),
    .rs1_sel(rs1_sel), .rs1_data(z_rs1_data), .rs1_busy(z_rs1_busy),
    .rs2_sel(rs2_sel), .rs2_data(z_rs2_data), .rs2_busy(z_rs2_busy),
    .busy_vec(z_busy_vec), .regs_flat(z_regs_flat));

  rd_wb_regfile #(.DATA_W(16), .NUM_REGS(12), .ZERO_REG(0)) u_n (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_sel(iss_sel),
    .rs1_sel(rs1_sel), .rs1_data(n_rs1_data), .rs1_busy(n_rs1_busy),
    .rs2_sel(rs2_sel), .rs2_data(n_rs2_data), .rs2_busy(n_rs2_busy),
    .busy_vec(n_busy_vec), .regs_flat(n_regs_flat));

  typedef struct {
    logic        wbv;
    logic [3:0]  wbs;
    logic [15:0] wbd;
    logic        isv;
    logic [3:0]  iss;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [15:0] e1d;
    logic        e1b;
    logic [15:0] e2d;
    logic        e2b;
    logic [15:0] ebv;
  } vec_t;

  vec_t         vt [10];
  int           n_chk = 0;
  int           n_err = 0;
  logic [255:0] exp_flat;
  data_t        bp_exp;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  // Drive one cycle of requests, then drop the valids so the reads that
  // follow reflect stored state only.
  task automatic step(input logic wbv, input logic [3:0] wbs, input logic [15:0] wbd,
                      input logic isv, input logic [3:0] iss);
    @(negedge clk);
    wb_valid = wbv; wb_sel = wbs; wb_data = wbd;
    iss_valid = isv; iss_sel = iss;
    @(posedge clk);
    #1;
    wb_valid = 1'b0; iss_valid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; wb_valid = 1'b0; iss_valid = 1'b0;
    #1;
  endtask

  initial begin
    //              wbv  wbs   wbd       isv  iss  r1  r2  e1d       e1b  e2d       e2b  ebv
    vt[0] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd5, 4'd5,  4'd0,  16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0020};
    vt[1] = '{1'b1, 4'd5,  16'hBEEF, 1'b0, 4'd0, 4'd5,  4'd0,  16'hBEEF, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[2] = '{1'b1, 4'd3,  16'h1234, 1'b1, 4'd3, 4'd3,  4'd5,  16'h1234, 1'b1, 16'hBEEF, 1'b0, 16'h0008};
    vt[3] = '{1'b1, 4'd3,  16'h5555, 1'b0, 4'd0, 4'd3,  4'd15, 16'h5555, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[4] = '{1'b1, 4'd0,  16'h00AA, 1'b1, 4'd0, 4'd0,  4'd3,  16'h00AA, 1'b1, 16'h5555, 1'b0, 16'h0001};
    vt[5] = '{1'b1, 4'd15, 16'hFFFF, 1'b1, 4'd9, 4'd15, 4'd9,  16'hFFFF, 1'b0, 16'h0000, 1'b1, 16'h0201};
    vt[6] = '{1'b1, 4'd0,  16'h0BB0, 1'b1, 4'd9, 4'd9,  4'd0,  16'h0000, 1'b1, 16'h0BB0, 1'b0, 16'h0200};
    vt[7] = '{1'b1, 4'd9,  16'h1357, 1'b0, 4'd0, 4'd9,  4'd5,  16'h1357, 1'b0, 16'hBEEF, 1'b0, 16'h0000};
    vt[8] = '{1'b1, 4'd2,  16'h2222, 1'b0, 4'd0, 4'd2,  4'd4,  16'h2222, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vt[9] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 4'd15, 4'd3,  16'hFFFF, 1'b0, 16'h5555, 1'b0, 16'h0000};

    // Reset state on all three instances.
    do_reset();
    rs1_sel = 4'd5; rs2_sel = 4'd11;
    #1;
    chk("rst_rs1_data", d_rs1_data, 0);
    chk("rst_rs2_data", d_rs2_data, 0);
    chk("rst_busy_vec", d_busy_vec, 0);
    chk("rst_regs_flat", d_regs_flat, 0);
    chk("rst_z_regs_flat", z_regs_flat, 0);
    chk("rst_n_regs_flat", n_regs_flat, 0);

    // Main table on the default instance.
    for (int i = 0; i < 10; i++) begin
      rs1_sel = vt[i].r1; rs2_sel = vt[i].r2;
      step(vt[i].wbv, vt[i].wbs, vt[i].wbd, vt[i].isv, vt[i].iss);
      chk($sformatf("v%0d_rs1_data", i), d_rs1_data, vt[i].e1d);
      chk($sformatf("v%0d_rs1_busy", i), d_rs1_busy, vt[i].e1b);
      chk($sformatf("v%0d_rs2_data", i), d_rs2_data, vt[i].e2d);
      chk($sformatf("v%0d_rs2_busy", i), d_rs2_busy, vt[i].e2b);
      chk($sformatf("v%0d_busy_vec", i), d_busy_vec, vt[i].ebv);
    end
    exp_flat = '0;
    exp_flat[0*16 +: 16]  = 16'h0BB0;
    exp_flat[2*16 +: 16]  = 16'h2222;
    exp_flat[3*16 +: 16]  = 16'h5555;
    exp_flat[5*16 +: 16]  = 16'hBEEF;
    exp_flat[9*16 +: 16]  = 16'h1357;
    exp_flat[15*16 +: 16] = 16'hFFFF;
    chk("table_regs_flat", d_regs_flat, exp_flat);

    // Zero register: write and issue to reg 0 are ignored when ZERO_REG=1.
    do_reset();
    rs1_sel = 4'd0; rs2_sel = 4'd0;
    step(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0);
    chk("z_rs1_data", z_rs1_data, 0);
    chk("z_rs1_busy", z_rs1_busy, 0);
    chk("z_busy_vec", z_busy_vec, 0);
    chk("z_regs_flat", z_regs_flat, 0);
    chk("d_reg0_data", d_rs1_data, 16'hFFFF);
    chk("d_reg0_busy", d_rs1_busy, 1);

    // Out of range on the 12-register instance.
    do_reset();
    rs1_sel = 4'd14; rs2_sel = 4'd13;
    step(1'b1, 4'd13, 16'h7777, 1'b1, 4'd13);
    chk("n_regs_flat", n_regs_flat, 0);
    chk("n_busy_vec", n_busy_vec, 0);
    chk("n_rs1_data_oor", n_rs1_data, 0);
    chk("n_rs1_busy_oor", n_rs1_busy, 0);
    chk("n_rs2_data_oor", n_rs2_data, 0);
    chk("d_reg13_data", d_rs2_data, 16'h7777);
    chk("d_reg13_busy", d_rs2_busy, 1);

    // Same-cycle read of a register being written back.
    do_reset();
    @(negedge clk);
    rs2_sel = 4'd7;
    wb_valid = 1'b1; wb_sel = 4'd7; wb_data = 16'hA5A5;
    #1;
`ifdef RD_WB_REGFILE_BYPASS_EN
    bp_exp = 16'hA5A5;
`else
    bp_exp = 16'h0000;
`endif
    chk("same_cycle_rs2_data", d_rs2_data, bp_exp);
    chk("same_cycle_rs2_busy", d_rs2_busy, 0);
    iss_valid = 1'b1; iss_sel = 4'd7;
    #1;
`ifdef RD_WB_REGFILE_BYPASS_EN
    chk("same_cycle_rs2_busy_iss", d_rs2_busy, 1);
`else
    chk("same_cycle_rs2_busy_iss", d_rs2_busy, 0);
`endif
    @(posedge clk);
    #1;
    wb_valid = 1'b0; iss_valid = 1'b0;
    #1;
    chk("after_wb_rs2_data", d_rs2_data, 16'hA5A5);
    chk("after_wb_rs2_busy", d_rs2_busy, 1);

    // Reset wins over a simultaneous write-back and issue.
    @(negedge clk);
    rst = 1'b1;
    wb_valid = 1'b1; wb_sel = 4'd5; wb_data = 16'h1111;
    iss_valid = 1'b1; iss_sel = 4'd6;
    @(posedge clk);
    #1;
    rst = 1'b0; wb_valid = 1'b0; iss_valid = 1'b0;
    #1;
    chk("rst_wb_regs_flat", d_regs_flat, 0);
    chk("rst_wb_busy_vec", d_busy_vec, 0);
    chk("rst_wb_rs2_data", d_rs2_data, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule : tb_rd_wb_regfile
`default_nettype wire
